// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit for the E stage.
//
// Owns the HI/LO registers. mult/multu/div/divu are accepted when idle,
// the result is computed at acceptance and held in a latch, and it is
// committed to HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles. A divide
// by zero occupies the full divide latency but leaves HI/LO unchanged.
// mfhi/mflo reads are combinational. mthi/mtlo writes are applied only
// while idle.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset, clears all state
//   en       in   E-stage instruction valid
//   flush    in   synchronous abort of an in-flight md operation
//   MDUType  in   5-bit op: 0 mfhi, 1 mflo, 2 mthi, 3 mtlo,
//                 4 mult, 5 multu, 6 div, 7 divu, other = none
//   A, B     in   rs / rt operands
//   start    out  en and op is mult/multu/div/divu (combinational)
//   busy     out  md operation in flight (registered)
//   MDUO     out  HI for mfhi, LO for mflo, 0 otherwise
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [4:0]       MDUType,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] MDUO
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [4:0] OP_MFHI = 5'd0;
    localparam logic [4:0] OP_MFLO = 5'd1;
    localparam logic [4:0] OP_MTHI = 5'd2;
    localparam logic [4:0] OP_MTLO = 5'd3;

    // Two's-complement negate when cond is set; used for sign restoration
    // after an unsigned magnitude divide.
    function automatic logic [WIDTH-1:0] neg_if(input logic cond, input logic [WIDTH-1:0] v);
        neg_if = cond ? (~v + 1'b1) : v;
    endfunction

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic             r_res_wr;

    logic             w_is_md;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_accept;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0]        w_prod_u;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_den_s;
    logic [WIDTH-1:0] w_den_u;
    logic [WIDTH-1:0] w_q_s;
    logic [WIDTH-1:0] w_r_s;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // Ops 4..7 share the pattern 001xx; the low two bits select the op.
    assign w_is_md  = (MDUType[4:2] == 3'b001);
    assign w_is_div = MDUType[1];
    assign w_b_zero = (B == '0);
    assign start    = en && w_is_md;
    assign w_accept = start && !r_busy && !flush;

    assign w_prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign w_prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide on magnitudes. For most-negative / -1 the magnitude of A
    // is 2^(WIDTH-1) as an unsigned value, so the quotient re-negates to the
    // most-negative pattern and the remainder is 0 without a special case.
    // A zero divisor is replaced by 1 only to keep the divider defined; that
    // result is never committed.
    assign w_abs_a = neg_if(A[WIDTH-1], A);
    assign w_abs_b = neg_if(B[WIDTH-1], B);
    assign w_den_s = w_b_zero ? WIDTH'(1) : w_abs_b;
    assign w_den_u = w_b_zero ? WIDTH'(1) : B;
    assign w_q_s   = w_abs_a / w_den_s;
    assign w_r_s   = w_abs_a % w_den_s;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        case (MDUType[1:0])
            2'd0: begin
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
            end
            2'd2: begin
                w_res_lo = neg_if(A[WIDTH-1] ^ B[WIDTH-1], w_q_s);
                w_res_hi = neg_if(A[WIDTH-1], w_r_s);
            end
            default: begin
                w_res_lo = A / w_den_u;
                w_res_hi = A % w_den_u;
            end
        endcase
    end

    always_comb begin
        MDUO = '0;
        if (MDUType == OP_MFHI) begin
            MDUO = r_hi;
        end else if (MDUType == OP_MFLO) begin
            MDUO = r_lo;
        end
    end

    assign busy = r_busy;

    // Counter holds the remaining busy cycles minus one; the result is
    // committed on the edge where it is already zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
        end else if (r_busy) begin
            if (flush) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_cnt == '0) begin
                r_busy <= 1'b0;
                if (r_res_wr) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (w_accept) begin
            r_busy   <= 1'b1;
            r_cnt    <= w_is_div ? DIV_LOAD : MULT_LOAD;
            r_res_hi <= w_res_hi;
            r_res_lo <= w_res_lo;
            r_res_wr <= !(w_is_div && w_b_zero);
        end else if (en && (MDUType == OP_MTHI)) begin
            r_hi <= A;
        end else if (en && (MDUType == OP_MTLO)) begin
            r_lo <= A;
        end
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core, driven by the 5-bit `MDUType` code from CU. It owns the HI/LO registers and executes mult/multu/div/divu with configurable latency. It serves mfhi/mflo reads and mthi/mtlo writes, and exports `start`/`busy` so the hazard unit can stall D-stage md/mf/mt instructions. Beyond the previous fixed-width, fixed-latency MDU, it adds an operand width parameter, separate multiply and divide latencies, and a flush input that aborts an in-flight operation.

## Interface
- `WIDTH`, 32: operand, HI and LO width (≥ 2).
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥ 1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥ 1).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `en`  in  1  E-stage instruction valid (0 for bubbles).
- `flush`  in  1  synchronous abort of an in-flight md operation.
- `MDUType`  in  5  0 mfhi, 1 mflo, 2 mthi, 3 mtlo, 4 mult, 5 multu, 6 div, 7 divu, 31 none; any other value is none.
- `A`  in  WIDTH  rs operand.
- `B`  in  WIDTH  rt operand.
- `start`  out  1  combinational: `en` and MDUType in 4..7.
- `busy`  out  1  registered: operation in flight.
- `MDUO`  out  WIDTH  combinational: HI for mfhi, LO for mflo, 0 otherwise.

## Operation
- State: HI, LO, busy, a down-counter (width ≥ clog2(max latency)+1), and a latched result (or latched operands and op).
- IDLE → RUN:
  - Condition: `en` and MDUType in 4..7, `busy`=0, `flush`=0.
  - Capture the op and A/B, or the computed result.
  - Load the counter with latency−1 and set `busy`.
- RUN:
  - Each cycle, decrement the counter.
  - When the counter is 0 at an edge: write the result to HI/LO, clear `busy`, return to IDLE.
- mult: signed 2·WIDTH product; HI = upper half, LO = lower half.
- multu: same as mult with unsigned operands.
- div: signed; LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - Special case A = most-negative, B = −1: LO = most-negative, HI = 0.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu): runs the full DIV_CYCLES busy period, then HI/LO are left unchanged.
- mthi/mtlo:
  - When `en` and `busy`=0, write A to HI/LO at the edge.
  - While `busy`, they are ignored; HI/LO are not corrupted.
- A new md op arriving while `busy` is ignored. The hazard unit guarantees this never happens; it stalls D when `start|busy` and the D instruction is md/mf/mt.
- `flush`:
  - If `busy`, clear `busy` and the counter at the next edge; HI/LO keep their pre-operation values.
  - `flush` with `start` in the same cycle: the operation is not accepted.
  - `flush` has no effect when idle.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, counter = 0. `MDUO` = 0 and `start` = 0 whenever inputs are idle.
- Accept at edge E0. `busy` = 1 in the cycles following E0 through edge E0+L, where L = MULT_CYCLES or DIV_CYCLES.
  - At edge E0+L, HI/LO update and `busy` falls.
  - `busy` is therefore high for exactly L cycles.
- An mfhi/mflo in the cycle after `busy` falls sees the new value.
- mthi/mtlo at edge E writes the register; `MDUO` reflects it combinationally from the following cycle.
- Back-to-back: a new md op may be accepted in the first cycle where `busy` = 0.
- Reset asserted mid-operation: immediately clears `busy`, HI and LO, with no clock edge required.

## Test plan
- mult, A=0xFFFFFFFF, B=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; then mfhi → MDUO=0xFFFFFFFF.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE; div A=−7, B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=5, B=0 with HI/LO preloaded to 0xAA/0xBB via mthi/mtlo → 10 busy cycles, then HI=0xAA, LO=0xBB.
- div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0; mtlo 0x1234 presented during `busy` → LO unchanged.
- div in flight, `flush` pulsed in busy cycle 3 → `busy`=0 after the next edge, HI/LO equal their pre-div values; the next mult is accepted immediately.
- Reset driven low mid-mult (asynchronously, between edges) → `busy`, HI, LO read 0 before the next edge. Re-run with WIDTH=8, MULT_CYCLES=1: mult 0x7F·0x02 → HI=0x00, LO=0xFE after 1 busy cycle.
